// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, combinational instruction ROM, RUN/HALT control.
// Latency: pc_out/im_out are valid in the same cycle; redirect/stall act on the next edge.
// Backpressure: stall holds the PC; redirect overrides stall; HALT holds until redirect or reset.
module if_fetch_unit #(
    parameter logic [31:0]            PC_RESET  = 32'h0000_0000,
    parameter int                     IM_DEPTH  = 256,
    parameter logic [IM_DEPTH*32-1:0] IM_INIT   = '0,
    parameter logic [31:0]            HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic [31:0] pc_add_out,
    output logic [31:0] im_out,
    output logic        fetch_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam int AW = $clog2(IM_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic [31:0]   rom_word;
    logic [31:0]   pc_plus4;
    logic [31:0]   redirect_tgt;
    logic          accept;

    // Word-addressed ROM; anything past the image reads as a NOP.
    assign word_idx = pc_q[AW+1:2];
    assign in_range = (pc_q[31:AW+2] == '0);
    assign rom_word = in_range ? IM_INIT[{word_idx, 5'b0} +: 32] : 32'h0;

    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    assign fetch_valid = (state_q == RUN) && !reset;
    assign im_out      = fetch_valid ? rom_word : 32'h0;
    assign accept      = fetch_valid && !stall && !redirect;

    assign pc_out      = pc_q;
    assign pc_add_out  = pc_plus4;
    assign halted      = (state_q == HALT);
    assign fetch_count = cnt_q;

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (redirect) begin
            pc_d    = redirect_tgt;
            state_d = RUN;
        end else if (accept) begin
            cnt_d = cnt_q + 32'd1;
            // The halt word is counted but the PC parks on its address.
            if (im_out == HALT_WORD) begin
                state_d = HALT;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            state_q <= RUN;
            cnt_q   <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_if_fetch_unit;

    localparam int DEPTH = 32;

    function automatic logic [DEPTH*32-1:0] mk_img();
        logic [DEPTH*32-1:0] r;
        for (int i = 0; i < DEPTH; i++)
            r[i*32 +: 32] = (i == 5) ? 32'hFFFF_FFFF : (32'hA000_0000 + 32'(i));
        return r;
    endfunction

    localparam logic [DEPTH*32-1:0] IMG = mk_img();

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] pc_add_out;
    logic [31:0] im_out;
    logic        fetch_valid;
    logic        halted;
    logic [31:0] fetch_count;

    if_fetch_unit #(
        .PC_RESET (32'h0000_0000),
        .IM_DEPTH (DEPTH),
        .IM_INIT  (IMG),
        .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pc_out     (pc_out),
        .pc_add_out (pc_add_out),
        .im_out     (im_out),
        .fetch_valid(fetch_valid),
        .halted     (halted),
        .fetch_count(fetch_count)
    );

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] im;
        logic        fv;
        logic        h;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_id = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL step%0d %s: got %h expected %h", id, name, act, want);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.id, "pc_out",      pc_out,             e.pc);
            chk(e.id, "pc_add_out",  pc_add_out,         e.pc + 32'd4);
            chk(e.id, "im_out",      im_out,             e.im);
            chk(e.id, "fetch_valid", {31'b0, fetch_valid}, {31'b0, e.fv});
            chk(e.id, "halted",      {31'b0, halted},      {31'b0, e.h});
            chk(e.id, "fetch_count", fetch_count,        e.cnt);
        end
    end

    // Drive one cycle of inputs and record the outputs expected during that cycle.
    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] rpc,
                        input logic [31:0] epc, input logic [31:0] eim,
                        input logic efv, input logic eh, input logic [31:0] ecnt);
        exp_t e;
        @(posedge clock);
        #1;
        reset       = r;
        stall       = s;
        redirect    = d;
        redirect_pc = rpc;
        step_id++;
        e.id  = step_id;
        e.pc  = epc;
        e.im  = eim;
        e.fv  = efv;
        e.h   = eh;
        e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        //   rst  stl  rd   rpc            pc             im             fv   h    cnt
        step(1'b1,1'b0,1'b0,32'h0,         32'h0000_0000, 32'h0,         1'b0,1'b0,32'd0);
        // free run 0,4,8,12
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0000, 32'hA000_0000, 1'b1,1'b0,32'd0);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0004, 32'hA000_0001, 1'b1,1'b0,32'd1);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0008, 32'hA000_0002, 1'b1,1'b0,32'd2);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_000C, 32'hA000_0003, 1'b1,1'b0,32'd3);
        // redirect back to 8, then two stalled cycles
        step(1'b0,1'b0,1'b1,32'h0000_0008, 32'h0000_0010, 32'hA000_0004, 1'b1,1'b0,32'd4);
        step(1'b0,1'b1,1'b0,32'h0,         32'h0000_0008, 32'hA000_0002, 1'b1,1'b0,32'd4);
        step(1'b0,1'b1,1'b0,32'h0,         32'h0000_0008, 32'hA000_0002, 1'b1,1'b0,32'd4);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0008, 32'hA000_0002, 1'b1,1'b0,32'd4);
        // misaligned redirect with concurrent stall
        step(1'b0,1'b1,1'b1,32'h0000_0043, 32'h0000_000C, 32'hA000_0003, 1'b1,1'b0,32'd5);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0040, 32'hA000_0010, 1'b1,1'b0,32'd5);
        // run into the halt word at 0x14
        step(1'b0,1'b0,1'b1,32'h0000_0010, 32'h0000_0044, 32'hA000_0011, 1'b1,1'b0,32'd6);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0010, 32'hA000_0004, 1'b1,1'b0,32'd6);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0014, 32'hFFFF_FFFF, 1'b1,1'b0,32'd7);
        step(1'b0,1'b1,1'b0,32'h0,         32'h0000_0014, 32'h0,         1'b0,1'b1,32'd8);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0014, 32'h0,         1'b0,1'b1,32'd8);
        step(1'b0,1'b0,1'b1,32'h0000_0000, 32'h0000_0014, 32'h0,         1'b0,1'b1,32'd8);
        // out-of-image fetch and PC wrap
        step(1'b0,1'b0,1'b1,32'h0000_0080, 32'h0000_0000, 32'hA000_0000, 1'b1,1'b0,32'd8);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0080, 32'h0,         1'b1,1'b0,32'd8);
        step(1'b0,1'b0,1'b1,32'hFFFF_FFFC, 32'h0000_0084, 32'h0,         1'b1,1'b0,32'd9);
        step(1'b0,1'b0,1'b0,32'h0,         32'hFFFF_FFFC, 32'h0,         1'b1,1'b0,32'd9);
        // halt again, then reset out of HALT
        step(1'b0,1'b0,1'b1,32'h0000_0010, 32'h0000_0000, 32'hA000_0000, 1'b1,1'b0,32'd10);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0010, 32'hA000_0004, 1'b1,1'b0,32'd10);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0014, 32'hFFFF_FFFF, 1'b1,1'b0,32'd11);
        step(1'b1,1'b0,1'b0,32'h0,         32'h0000_0014, 32'h0,         1'b0,1'b1,32'd12);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0000, 32'hA000_0000, 1'b1,1'b0,32'd0);
        // reset coinciding with a redirect
        step(1'b1,1'b0,1'b1,32'h0000_0040, 32'h0000_0004, 32'h0,         1'b0,1'b0,32'd1);
        step(1'b0,1'b1,1'b0,32'h0,         32'h0000_0000, 32'hA000_0000, 1'b1,1'b0,32'd0);
        step(1'b0,1'b0,1'b0,32'h0,         32'h0000_0000, 32'hA000_0000, 1'b1,1'b0,32'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
